// File: rtl/inst_encoder_pkg.sv
// Shared immediate-format codes, opcodes and instruction field positions
// for the instruction encoder and the immediate-type decoder.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_S = 3'b000,
    IMM_U = 3'b001,
    IMM_J = 3'b010,
    IMM_I = 3'b011
  } imm_type_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam int OPC_LSB    = 0;
  localparam int RD_LSB     = 7;
  localparam int F3_LSB     = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

endpackage

// File: rtl/inst_encoder_if.sv
// Request and encoded-instruction streams, both valid/ready handshakes.
// The master side produces requests and consumes encoded instructions.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_type, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr
  );

  modport slave (
    input  in_valid, in_type, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr
  );
endinterface

// File: rtl/inst_imm_pack.sv
// Scatters fields and immediate into a 32-bit instruction and flags range
// violations or unknown formats; purely combinational, no handshake.
module inst_imm_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output logic        illegal_o
);

  always_comb begin
    inst_o    = '0;
    illegal_o = 1'b0;
    inst_o[OPC_LSB +: 7] = opcode_i;
    case (type_i)
      IMM_I: begin
        inst_o[RD_LSB +: 5]   = rd_i;
        inst_o[F3_LSB +: 3]   = funct3_i;
        inst_o[RS1_LSB +: 5]  = rs1_i;
        inst_o[RS2_LSB +: 12] = imm_i[11:0];
        illegal_o = imm_i != {{20{imm_i[11]}}, imm_i[11:0]};
      end
      IMM_S: begin
        inst_o[RD_LSB +: 5]     = imm_i[4:0];
        inst_o[F3_LSB +: 3]     = funct3_i;
        inst_o[RS1_LSB +: 5]    = rs1_i;
        inst_o[RS2_LSB +: 5]    = rs2_i;
        inst_o[FUNCT7_LSB +: 7] = imm_i[11:5];
        illegal_o = imm_i != {{20{imm_i[11]}}, imm_i[11:0]};
      end
      IMM_U: begin
        inst_o[RD_LSB +: 5]  = rd_i;
        inst_o[F3_LSB +: 20] = imm_i[31:12];
        illegal_o = |imm_i[11:0];
      end
      IMM_J: begin
        inst_o[RD_LSB +: 5]  = rd_i;
        inst_o[F3_LSB +: 20] = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12]};
        illegal_o = imm_i[0] | (imm_i != {{11{imm_i[20]}}, imm_i[20:0]});
      end
      default: begin
        inst_o    = '0;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Encodes requests into a DEPTH-entry FIFO with a running output address; 1-cycle latency.
// in_ready = !full (no pop bypass); illegal requests are consumed, dropped and counted.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inst_encoder_if.slave          bus,
  output logic                   err,
  output logic [7:0]             err_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] CNT_ONE  = 1;

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [31:0] packed_inst;
  logic        illegal;
  logic        full, empty, accept, push, pop;

  inst_imm_pack u_pack (
    .type_i    (bus.in_type),
    .opcode_i  (bus.in_opcode),
    .funct3_i  (bus.in_funct3),
    .rd_i      (bus.in_rd),
    .rs1_i     (bus.in_rs1),
    .rs2_i     (bus.in_rs2),
    .imm_i     (bus.in_imm),
    .inst_o    (packed_inst),
    .illegal_o (illegal)
  );

  assign full   = cnt_q == FULL_CNT;
  assign empty  = cnt_q == '0;
  assign accept = bus.in_valid & ~full;
  assign push   = accept & ~illegal;
  assign pop    = ~empty & bus.out_ready;

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  // Gate the head so a drained FIFO shows zero rather than a stale entry.
  assign bus.out_inst  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.out_addr  = addr_q;
  assign err           = err_q;
  assign err_cnt       = err_cnt_q;
  assign level         = cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    addr_d    = pop ? addr_q + 32'd4 : addr_q;
    err_d     = accept & illegal;
    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= packed_inst;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encoding table, backpressure, async reset, saturation.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          NV    = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       err;
  logic [7:0] err_cnt;
  logic [2:0] level;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_addr;
  int          exp_errs;

  inst_encoder_if bus();

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err     (err),
    .err_cnt (err_cnt),
    .level   (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  typ;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        bad;
    logic [31:0] inst;
  } vec_t;

  vec_t        vt[NV];
  logic [31:0] mq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] typ, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    bus.in_type   = typ;
    bus.in_opcode = opc;
    bus.in_funct3 = f3;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_addr = BASE;
    exp_errs = 0;
  endtask

  // addi xk, x0, k
  function automatic logic [31:0] addi_k(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h0000_0013;
  endfunction

  initial begin
    int  cyc;
    int  idx;
    int  popped;
    logic acc;
    logic pop;

    vt[0]  = '{"i_addi5",   IMM_I, OPC_OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5,          1'b0, 32'h0050_0093};
    vt[1]  = '{"s_sw8",     IMM_S, OPC_STORE,  3'b010, 5'd0, 5'd1, 5'd2, 32'd8,          1'b0, 32'h0020_A423};
    vt[2]  = '{"u_lui",     IMM_U, OPC_LUI,    3'b000, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  1'b0, 32'h1234_52B7};
    vt[3]  = '{"j_jal800",  IMM_J, OPC_JAL,    3'b000, 5'd1, 5'd0, 5'd0, 32'h0000_0800,  1'b0, 32'h0010_00EF};
    vt[4]  = '{"j_odd",     IMM_J, OPC_JAL,    3'b000, 5'd1, 5'd0, 5'd0, 32'h0000_0801,  1'b1, 32'h0};
    vt[5]  = '{"i_800",     IMM_I, OPC_OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, 32'h0000_0800,  1'b1, 32'h0};
    vt[6]  = '{"type7",     3'b111, OPC_OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0,         1'b1, 32'h0};
    vt[7]  = '{"i_neg1",    IMM_I, OPC_OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,  1'b0, 32'hFFF0_0093};
    vt[8]  = '{"i_7ff",     IMM_I, OPC_OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, 32'h0000_07FF,  1'b0, 32'h7FF0_0093};
    vt[9]  = '{"i_m2049",   IMM_I, OPC_OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFF_F7FF,  1'b1, 32'h0};
    vt[10] = '{"s_m2048",   IMM_S, OPC_STORE,  3'b010, 5'd0, 5'd1, 5'd2, 32'hFFFF_F800,  1'b0, 32'h8020_A023};
    vt[11] = '{"u_lowbit",  IMM_U, OPC_LUI,    3'b000, 5'd5, 5'd0, 5'd0, 32'h1234_5001,  1'b1, 32'h0};
    vt[12] = '{"j_neg2",    IMM_J, OPC_JAL,    3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFE,  1'b0, 32'hFFFF_F0EF};
    vt[13] = '{"j_min",     IMM_J, OPC_JAL,    3'b000, 5'd1, 5'd0, 5'd0, 32'hFFF0_0000,  1'b0, 32'h8000_00EF};
    vt[14] = '{"j_ovf",     IMM_J, OPC_JAL,    3'b000, 5'd1, 5'd0, 5'd0, 32'h0010_0000,  1'b1, 32'h0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'b000, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);

    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_err",       32'(err),           32'd0);
    check("rst_err_cnt",   32'(err_cnt),       32'd0);
    check("rst_level",     32'(level),         32'd0);
    check("rst_out_inst",  bus.out_inst,       32'd0);
    check("rst_out_addr",  bus.out_addr,       BASE);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);

    @(negedge clk);
    rst_n    = 1'b1;
    exp_addr = BASE;
    exp_errs = 0;

    // Single requests, one at a time, with the sink always ready.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].typ, vt[i].opc, vt[i].f3, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      check({vt[i].name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (vt[i].bad) begin
        if (exp_errs < 255) exp_errs++;
        check({vt[i].name, "_err"},       32'(err),           32'd1);
        check({vt[i].name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({vt[i].name, "_err_cnt"},   32'(err_cnt),       32'(exp_errs));
        check({vt[i].name, "_level"},     32'(level),         32'd0);
      end else begin
        check({vt[i].name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({vt[i].name, "_inst"},      bus.out_inst,       vt[i].inst);
        check({vt[i].name, "_addr"},      bus.out_addr,       exp_addr);
        check({vt[i].name, "_err"},       32'(err),           32'd0);
        check({vt[i].name, "_level"},     32'(level),         32'd1);
        exp_addr = exp_addr + 32'd4;
      end
      @(negedge clk);
      check({vt[i].name, "_err_end"},   32'(err),           32'd0);
      check({vt[i].name, "_drained"},   32'(bus.out_valid), 32'd0);
    end

    // Five back-to-back requests against a stalled sink, then release it.
    do_reset();
    cyc    = 0;
    idx    = 0;
    popped = 0;
    while ((idx < 5 || mq.size() != 0) && cyc < 40) begin
      bus.out_ready = (cyc >= 7);
      bus.in_valid  = (idx < 5);
      drive(IMM_I, OPC_OP_IMM, 3'b000, 5'(idx + 1), 5'd0, 5'd0, 32'(idx + 1));
      check("bp_in_ready",  32'(bus.in_ready),  32'(mq.size() < DEPTH));
      check("bp_level",     32'(level),         32'(mq.size()));
      check("bp_out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("bp_head_inst", bus.out_inst, mq[0]);
        check("bp_head_addr", bus.out_addr, exp_addr);
      end
      if (cyc == 6) begin
        check("bp_full_level",    32'(level),        32'd4);
        check("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
      end
      acc = bus.in_valid && (mq.size() < DEPTH);
      pop = (mq.size() > 0) && bus.out_ready;
      @(posedge clk);
      if (pop) begin
        void'(mq.pop_front());
        exp_addr = exp_addr + 32'd4;
        popped++;
      end
      if (acc) begin
        mq.push_back(addi_k(idx + 1));
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("bp_popped",    32'(popped),       32'd5);
    check("bp_final_addr", bus.out_addr,     BASE + 32'd20);

    // Reset with three entries queued and an err pulse in flight.
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(IMM_I, OPC_OP_IMM, 3'b000, 5'(k), 5'd0, 5'd0, 32'(k));
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    drive(3'b111, OPC_OP_IMM, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("mr_err_pulse", 32'(err),     32'd1);
    check("mr_level_pre", 32'(level),   32'd3);
    check("mr_errcnt_pre", 32'(err_cnt), 32'd1);
    check("mr_head_pre",  bus.out_inst, addi_k(1));
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", 32'(bus.out_valid), 32'd0);
    check("mr_level",     32'(level),         32'd0);
    check("mr_out_addr",  bus.out_addr,       BASE);
    check("mr_err",       32'(err),           32'd0);
    check("mr_err_cnt",   32'(err_cnt),       32'd0);
    check("mr_out_inst",  bus.out_inst,       32'd0);
    check("mr_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous illegal requests drive the error counter into saturation.
    drive(3'b111, OPC_OP_IMM, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.in_valid = 1'b1;
    repeat (254) @(posedge clk);
    @(negedge clk);
    check("sat_254", 32'(err_cnt), 32'd254);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("sat_255",     32'(err_cnt), 32'd255);
    check("sat_err_hi",  32'(err),     32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("sat_err_lo",  32'(err),     32'd0);
    check("sat_hold",    32'(err_cnt), 32'd255);
    check("sat_level",   32'(level),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
